// File: rtl/uart_note_scheduler.sv
// uart_note_scheduler
// Shares one byte-wide UART transmitter among NUM_SRC note sources. Each source
// posts a note into its own buffer. Pending sources are granted round-robin, and
// each grant sends a two-byte frame {HDR_NIBBLE, id} then {note} over a
// start/busy handshake with the transmitter.
module uart_note_scheduler #(
  parameter int         NUM_SRC     = 4,
  parameter logic [3:0] HDR_NIBBLE  = 4'hA,
  parameter int         ACK_TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_SRC-1:0]     i_src_valid,
  input  logic [8*NUM_SRC-1:0]   i_src_note,
  input  logic                   i_utx_busy,
  output logic                   o_utx_start,
  output logic [7:0]             o_utx_data,
  output logic [3:0]             o_grant_id,
  output logic                   o_frame_active,
  output logic                   o_frame_done,
  output logic [NUM_SRC-1:0]     o_pending,
  output logic [7:0]             o_overrun_cnt,
  output logic                   o_timeout_err
);

  typedef enum logic [3:0] {
    S_IDLE, S_HDR_START, S_HDR_ACK, S_HDR_WAIT,
    S_DAT_START, S_DAT_ACK, S_DAT_WAIT, S_DONE, S_ABORT
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [NUM_SRC-1:0] r_pending;
  logic [7:0]         r_note_buf [16];
  logic [7:0]         r_frame_note;
  logic [3:0]         r_grant_id;
  logic [3:0]         r_rr_ptr;
  logic [7:0]         r_ovr_cnt;
  logic [6:0]         r_to_cnt;
  logic               r_timeout_err;

  logic [15:0]        w_pend_ext;
  logic               w_found;
  logic [3:0]         w_gnt;
  logic [4:0]         w_idx;
  logic               w_grant_fire;
  logic               w_to_fire;
  logic [NUM_SRC-1:0] w_clr;
  logic [NUM_SRC-1:0] w_ovr_hit;
  logic [NUM_SRC-1:0] w_pend_next;
  logic [4:0]         w_ovr_num;
  logic [8:0]         w_ovr_sum;
  logic [7:0]         w_ovr_next;
  logic [7:0]         w_hdr_byte;

  // Widen the pending vector so a 4-bit id can index it for any NUM_SRC.
  assign w_pend_ext = 16'(r_pending);
  assign w_hdr_byte = {HDR_NIBBLE, r_grant_id};

  // Per-source flag update: a new note always sets pending, even while that
  // source is being granted, so the newer note is never lost.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    assign w_clr[gi]       = w_grant_fire && (w_gnt == 4'(gi));
    assign w_ovr_hit[gi]   = i_src_valid[gi] && r_pending[gi] && !w_clr[gi];
    assign w_pend_next[gi] = i_src_valid[gi] | (r_pending[gi] & ~w_clr[gi]);
  end

  // Round-robin search: first pending source at or after r_rr_ptr, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_idx   = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      w_idx = {1'b0, r_rr_ptr} + 5'(k);
      if (w_idx >= 5'(NUM_SRC)) begin
        w_idx = w_idx - 5'(NUM_SRC);
      end
      if (w_pend_ext[w_idx[3:0]]) begin
        w_found = 1'b1;
        w_gnt   = w_idx[3:0];
      end
    end
  end

  // Count overwritten notes this cycle and add them with saturation at 255.
  always_comb begin
    w_ovr_num = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_ovr_num = w_ovr_num + 5'(w_ovr_hit[i]);
    end
    w_ovr_sum  = {1'b0, r_ovr_cnt} + 9'(w_ovr_num);
    w_ovr_next = (w_ovr_sum > 9'd255) ? 8'hFF : w_ovr_sum[7:0];
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state and handshake outputs, decoded from the current state.
  always_comb begin
    w_state_next   = r_state;
    o_utx_start    = 1'b0;
    o_utx_data     = 8'h00;
    o_frame_active = 1'b0;
    o_frame_done   = 1'b0;
    w_grant_fire   = 1'b0;
    w_to_fire      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grant_fire = 1'b1;
          w_state_next = S_HDR_START;
        end
      end
      S_HDR_START: begin
        o_utx_start    = 1'b1;
        o_utx_data     = w_hdr_byte;
        o_frame_active = 1'b1;
        w_state_next   = S_HDR_ACK;
      end
      S_HDR_ACK: begin
        o_utx_data     = w_hdr_byte;
        o_frame_active = 1'b1;
        if (i_utx_busy) begin
          w_state_next = S_HDR_WAIT;
        end else if (r_to_cnt == 7'(ACK_TIMEOUT - 1)) begin
          w_to_fire    = 1'b1;
          w_state_next = S_ABORT;
        end
      end
      S_HDR_WAIT: begin
        o_utx_data     = w_hdr_byte;
        o_frame_active = 1'b1;
        if (!i_utx_busy) begin
          w_state_next = S_DAT_START;
        end
      end
      S_DAT_START: begin
        o_utx_start    = 1'b1;
        o_utx_data     = r_frame_note;
        o_frame_active = 1'b1;
        w_state_next   = S_DAT_ACK;
      end
      S_DAT_ACK: begin
        o_utx_data     = r_frame_note;
        o_frame_active = 1'b1;
        if (i_utx_busy) begin
          w_state_next = S_DAT_WAIT;
        end else if (r_to_cnt == 7'(ACK_TIMEOUT - 1)) begin
          w_to_fire    = 1'b1;
          w_state_next = S_ABORT;
        end
      end
      S_DAT_WAIT: begin
        o_utx_data     = r_frame_note;
        o_frame_active = 1'b1;
        if (!i_utx_busy) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        o_frame_done = 1'b1;
        w_state_next = S_IDLE;
      end
      S_ABORT: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Note capture, grant bookkeeping, ack timeout counter and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending     <= '0;
      r_frame_note  <= '0;
      r_grant_id    <= '0;
      r_rr_ptr      <= '0;
      r_ovr_cnt     <= '0;
      r_to_cnt      <= '0;
      r_timeout_err <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        r_note_buf[i] <= '0;
      end
    end else begin
      r_pending <= w_pend_next;
      r_ovr_cnt <= w_ovr_next;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (i_src_valid[i]) begin
          r_note_buf[i] <= i_src_note[8*i +: 8];
        end
      end
      // The frame takes the buffered note before any same-cycle overwrite.
      if (w_grant_fire) begin
        r_frame_note <= r_note_buf[w_gnt];
        r_grant_id   <= w_gnt;
        r_rr_ptr     <= (w_gnt == 4'(NUM_SRC - 1)) ? 4'd0 : w_gnt + 4'd1;
      end
      if (o_utx_start) begin
        r_to_cnt <= '0;
      end else if (r_state == S_HDR_ACK || r_state == S_DAT_ACK) begin
        r_to_cnt <= r_to_cnt + 7'd1;
      end
      if (w_to_fire) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign o_grant_id    = r_grant_id;
  assign o_pending     = r_pending;
  assign o_overrun_cnt = r_ovr_cnt;
  assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_note_scheduler.sv
// tb_uart_note_scheduler
// Drives note requests into the scheduler and models the UART transmitter's
// busy handshake. Expected frame bytes and grant ids are queued as requests are
// posted, then popped and compared as the scheduler emits them.
module tb_uart_note_scheduler;

  localparam int N        = 4;
  localparam int BUSY_LEN = 10;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     src_valid = '0;
  logic [8*N-1:0]   src_note = '0;
  logic             utx_busy = 1'b0;
  logic             utx_start;
  logic [7:0]       utx_data;
  logic [3:0]       grant_id;
  logic             frame_active;
  logic             frame_done;
  logic [N-1:0]     pending;
  logic [7:0]       overrun_cnt;
  logic             timeout_err;

  uart_note_scheduler #(.NUM_SRC(N), .HDR_NIBBLE(4'hA), .ACK_TIMEOUT(64)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_src_valid    (src_valid),
    .i_src_note     (src_note),
    .i_utx_busy     (utx_busy),
    .o_utx_start    (utx_start),
    .o_utx_data     (utx_data),
    .o_grant_id     (grant_id),
    .o_frame_active (frame_active),
    .o_frame_done   (frame_done),
    .o_pending      (pending),
    .o_overrun_cnt  (overrun_cnt),
    .o_timeout_err  (timeout_err)
  );

  always #20 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         done_cnt = 0;
  int         start_cnt = 0;
  int         busy_cnt = 0;
  bit         busy_en = 1'b1;
  logic [7:0] exp_q [$];
  logic [3:0] gid_q [$];
  logic [7:0] exp_b;
  logic [3:0] exp_g;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Transmitter model: busy rises the cycle start is seen and holds BUSY_LEN cycles.
  always @(negedge clk) begin
    if (rst) begin
      busy_cnt = 0;
    end else if (utx_start && busy_en) begin
      busy_cnt = BUSY_LEN;
    end
    utx_busy = (busy_cnt > 0);
    if (busy_cnt > 0) busy_cnt--;
  end

  // Output monitor: compare every transmitted byte and every completed frame.
  always @(negedge clk) begin
    if (!rst) begin
      if (utx_start) begin
        start_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %02h, required no transmission", utx_data);
        end else begin
          exp_b = exp_q.pop_front();
          $display("[%0t] tx byte %02h (expected %02h)", $time, utx_data, exp_b);
          chk("utx_byte", 32'(utx_data), 32'(exp_b));
        end
      end
      if (frame_done) begin
        done_cnt++;
        if (gid_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame_done: got grant %0d, required none", grant_id);
        end else begin
          exp_g = gid_q.pop_front();
          $display("[%0t] frame done grant %0d (expected %0d)", $time, grant_id, exp_g);
          chk("grant_order", 32'(grant_id), 32'(exp_g));
        end
      end
    end
  end

  task automatic post(input logic [N-1:0] mask, input logic [8*N-1:0] notes);
    @(negedge clk);
    src_valid = mask;
    src_note  = notes;
    @(negedge clk);
    src_valid = '0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((frame_active || pending != '0 || exp_q.size() != 0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      checks++;
      errors++;
      $display("FAIL %s_idle_timeout: got still busy after %0d cycles, required idle", name, n);
    end
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    int         src;
    logic [7:0] note;
    logic [7:0] hdr;
  } vec_t;

  vec_t tbl [4];

  initial begin
    int d0;
    int n;
    logic [N-1:0]   m;
    logic [8*N-1:0] nv;

    tbl[0] = '{1, 8'h04, 8'hA1};
    tbl[1] = '{0, 8'h7F, 8'hA0};
    tbl[2] = '{2, 8'h00, 8'hA2};
    tbl[3] = '{3, 8'hFF, 8'hA3};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({utx_start, utx_data, grant_id, frame_active, frame_done,
                              pending, overrun_cnt, timeout_err}), 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single-source frames from a table
    for (int t = 0; t < 4; t++) begin
      m = '0;
      m[tbl[t].src] = 1'b1;
      nv = '0;
      nv[8*tbl[t].src +: 8] = tbl[t].note;
      exp_q.push_back(tbl[t].hdr);
      exp_q.push_back(tbl[t].note);
      gid_q.push_back(4'(tbl[t].src));
      d0 = done_cnt;
      post(m, nv);
      @(negedge clk);
      chk("min_latency_start", 32'(utx_start), 32'h1);
      wait_idle("single");
      chk("single_done_count", 32'(done_cnt), 32'(d0 + 1));
      chk("single_pending", 32'(pending), 32'h0);
    end

    // Sources 0,2,3 together, then source 0 again during source 2's frame
    exp_q.push_back(8'hA0); exp_q.push_back(8'h11);
    exp_q.push_back(8'hA2); exp_q.push_back(8'h22);
    exp_q.push_back(8'hA3); exp_q.push_back(8'h33);
    exp_q.push_back(8'hA0); exp_q.push_back(8'h44);
    gid_q.push_back(4'd0); gid_q.push_back(4'd2);
    gid_q.push_back(4'd3); gid_q.push_back(4'd0);
    post(4'b1101, 32'h3322_0011);
    n = 0;
    while (!(frame_active && grant_id == 4'd2) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("rr_reach_src2", 32'(n < 500), 32'h1);
    post(4'b0001, 32'h0000_0044);
    wait_idle("rr");

    // Two notes for source 2 while it is still pending: latest wins
    exp_q.push_back(8'hA1); exp_q.push_back(8'h55);
    exp_q.push_back(8'hA2); exp_q.push_back(8'h04);
    gid_q.push_back(4'd1); gid_q.push_back(4'd2);
    post(4'b0010, 32'h0000_5500);
    post(4'b0100, 32'h0002_0000);
    post(4'b0100, 32'h0004_0000);
    chk("overrun_pending", 32'(pending), 32'h4);
    wait_idle("overrun");
    chk("overrun_cnt", 32'(overrun_cnt), 32'h1);

    // New note arrives in the grant cycle: old note goes out, new one follows
    exp_q.push_back(8'hA2); exp_q.push_back(8'h66);
    exp_q.push_back(8'hA2); exp_q.push_back(8'h77);
    gid_q.push_back(4'd2); gid_q.push_back(4'd2);
    @(negedge clk);
    src_valid = 4'b0100;
    src_note  = 32'h0066_0000;
    @(negedge clk);
    src_note  = 32'h0077_0000;
    @(negedge clk);
    src_valid = '0;
    chk("grant_cycle_pending", 32'(pending), 32'h4);
    wait_idle("grant_cycle");

    // Transmitter never acknowledges: abort after 64 ack cycles
    busy_en = 1'b0;
    d0 = done_cnt;
    exp_q.push_back(8'hA1);
    post(4'b0010, 32'h0000_EE00);
    n = 0;
    while (!utx_start && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("abort_hdr_start_seen", 32'(utx_start), 32'h1);
    for (int k = 1; k <= 65; k++) begin
      @(negedge clk);
      if (k == 10) begin
        src_valid = 4'b1000;
        src_note  = 32'hCC00_0000;
        exp_q.push_back(8'hA3);
        exp_q.push_back(8'hCC);
        gid_q.push_back(4'd3);
      end
      if (k == 11) src_valid = '0;
      if (k == 64) begin
        chk("timeout_not_yet", 32'(timeout_err), 32'h0);
        chk("active_before_abort", 32'(frame_active), 32'h1);
      end
      if (k == 65) begin
        chk("timeout_err_set", 32'(timeout_err), 32'h1);
        chk("abort_inactive", 32'(frame_active), 32'h0);
        chk("abort_no_done", 32'(frame_done), 32'h0);
        chk("abort_pending", 32'(pending), 32'h8);
      end
    end
    busy_en = 1'b1;
    chk("abort_done_count", 32'(done_cnt), 32'(d0));
    wait_idle("after_abort");
    chk("after_abort_done", 32'(done_cnt), 32'(d0 + 1));
    chk("timeout_sticky", 32'(timeout_err), 32'h1);

    // Reset in the middle of the data byte
    exp_q.push_back(8'hA2); exp_q.push_back(8'h99);
    n = start_cnt;
    post(4'b0100, 32'h0099_0000);
    d0 = 0;
    while (start_cnt < n + 2 && d0 < 200) begin
      @(negedge clk);
      d0++;
    end
    post(4'b0001, 32'h0000_00AB);
    chk("pre_reset_state", 32'({frame_active, pending}), 32'h11);
    #5;
    rst = 1'b1;
    #1;
    chk("midframe_reset_outputs", 32'({utx_start, utx_data, grant_id, frame_active, frame_done,
                                       pending, overrun_cnt, timeout_err}), 32'h0);
    exp_q.delete();
    gid_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    d0 = done_cnt;
    exp_q.push_back(8'hA1); exp_q.push_back(8'h5A);
    gid_q.push_back(4'd1);
    post(4'b0010, 32'h0000_5A00);
    wait_idle("post_reset");
    chk("post_reset_done", 32'(done_cnt), 32'(d0 + 1));

    chk("bytes_all_seen", 32'(exp_q.size()), 32'h0);
    chk("frames_all_seen", 32'(gid_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
